banco_ctrl: RTL and testbench

BANCO_CTRL -- requirements
Module: banco_ctrl

---
 rtl/banco_ctrl_pkg.sv | 16 +
 rtl/flanco_subida.sv | 25 ++
 rtl/banco_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_banco_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banco_ctrl_pkg.sv
// Purpose: shared FSM state encoding and bell tone codes for banco_ctrl.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package banco_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [7:0] TONE_NONE = 8'd0;
    localparam logic [7:0] TONE_KEY  = 8'd1;
    localparam logic [7:0] TONE_CLR  = 8'd2;

endpackage

// File: rtl/flanco_subida.sv
// Purpose: rising-edge detector; one registered pulse per 0->1 transition of din.
// Latency: evt is high in the cycle after the clock edge that first samples din high.
// Backpressure: none; a level held high yields a single event.
// Ports: clk, rst (async active-low), din (level input), evt (one-cycle event pulse).
module flanco_subida (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic evt
);

    logic prev;

    // History resets to 1 so a level already high at reset release is not an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= 1'b1;
            evt  <= 1'b0;
        end else begin
            prev <= din;
            evt  <= din & ~prev;
        end
    end

endmodule

// File: rtl/banco_ctrl.sv
// Purpose: keypad/clear controller for a 2^AW x DW colour bank with shadow copy and bell code.
// Latency: key write strobe 2 cycles after key_valid is sampled high; clear takes 2^AW cycles.
// Backpressure: events arriving while busy are held in one-deep pending slots (latest key wins).
// Ports: clk, rst (async active-low), key_valid/key_pos (keypad), clr_req (bulk clear),
//        wr_en/wr_addr/wr_data (bank write port), busy, caso (bell tone code).
// Option: define BANCO_CTRL_BELL_EN to build the tone timer; otherwise caso is tied to 0.
module banco_ctrl
    import banco_ctrl_pkg::*;
#(
    parameter int unsigned     AW       = 4,
    parameter int unsigned     DW       = 3,
    parameter logic [DW-1:0]   CLR_VAL  = '0,
    parameter logic [23:0]     BELL_CYC = 24'd5_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [AW-1:0] key_pos,
    input  logic          clr_req,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic [7:0]    caso
);

    localparam int unsigned DEPTH = 1 << AW;

    state_t        state;
    state_t        state_nxt;
    logic          key_evt;
    logic          clr_evt;
    logic [AW-1:0] key_pos_r;
    logic          key_pend;
    logic [AW-1:0] key_pend_pos;
    logic          clr_pend;
    logic          start_write;
    logic          start_clear;
    logic [AW-1:0] wr_pos;
    logic [DW-1:0] shadow [DEPTH];

    flanco_subida u_key_edge (
        .clk (clk),
        .rst (rst),
        .din (key_valid),
        .evt (key_evt)
    );

    flanco_subida u_clr_edge (
        .clk (clk),
        .rst (rst),
        .din (clr_req),
        .evt (clr_evt)
    );

    // The edge pulse is one cycle behind key_valid, so key_pos is delayed to match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_pos_r <= '0;
        end else begin
            key_pos_r <= key_pos;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Clear has priority over any key; a pending key is taken in the first free IDLE cycle.
    always_comb begin
        state_nxt   = state;
        start_write = 1'b0;
        start_clear = 1'b0;
        wr_pos      = key_pos_r;
        unique case (state)
            IDLE: begin
                if (clr_evt || clr_pend) begin
                    state_nxt   = CLEAR;
                    start_clear = 1'b1;
                end else if (key_evt) begin
                    state_nxt   = WRITE;
                    start_write = 1'b1;
                    wr_pos      = key_pos_r;
                end else if (key_pend) begin
                    state_nxt   = WRITE;
                    start_write = 1'b1;
                    wr_pos      = key_pend_pos;
                end
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            CLEAR: begin
                if (wr_addr == '1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign wr_en = (state == WRITE) || (state == CLEAR);
    assign busy  = wr_en;

    // Pending slots: a key that cannot start now (busy, or losing to a clear) is parked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_pend     <= 1'b0;
            key_pend_pos <= '0;
            clr_pend     <= 1'b0;
        end else begin
            if (key_evt && ((state != IDLE) || clr_evt || clr_pend)) begin
                key_pend     <= 1'b1;
                key_pend_pos <= key_pos_r;
            end else if (start_write) begin
                key_pend <= 1'b0;
            end

            if (clr_evt && (state == WRITE)) begin
                clr_pend <= 1'b1;
            end else if (start_clear) begin
                clr_pend <= 1'b0;
            end
        end
    end

    // Write port registers and the shadow copy; the shadow takes whatever the bank takes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr <= '0;
            wr_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            if (start_write) begin
                wr_addr <= wr_pos;
                wr_data <= shadow[wr_pos] + DW'(1);
            end else if (start_clear) begin
                wr_addr <= '0;
                wr_data <= CLR_VAL;
            end else if ((state == CLEAR) && (wr_addr != '1)) begin
                wr_addr <= wr_addr + AW'(1);
            end

            if (wr_en) begin
                shadow[wr_addr] <= wr_data;
            end
        end
    end

`ifdef BANCO_CTRL_BELL_EN
    logic [23:0] tone_tmr;

    // Code is loaded on the edge that completes the operation and held BELL_CYC cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            caso     <= TONE_NONE;
            tone_tmr <= '0;
        end else if (state == WRITE) begin
            caso     <= TONE_KEY;
            tone_tmr <= BELL_CYC;
        end else if ((state == CLEAR) && (wr_addr == '1)) begin
            caso     <= TONE_CLR;
            tone_tmr <= BELL_CYC;
        end else if (tone_tmr != 24'd0) begin
            tone_tmr <= tone_tmr - 24'd1;
            if (tone_tmr == 24'd1) begin
                caso <= TONE_NONE;
            end
        end
    end
`else
    localparam logic [23:0] BELL_CYC_UNUSED = BELL_CYC;
    assign caso = TONE_NONE;
`endif

endmodule

// File: tb/tb_banco_ctrl.sv
// Purpose: self-checking bench for banco_ctrl against a bank-level reference model.
// Latency: checks the 2-cycle key write latency and the 2^AW-cycle clear burst.
// Backpressure: exercises pending key/clear handling during WRITE and CLEAR.
module tb_banco_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] CLR = '0;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          key_valid = 1'b0;
    logic [AW-1:0] key_pos = '0;
    logic          clr_req = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic [7:0]    caso;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  bank_m[DEPTH];

    banco_ctrl #(
        .AW       (AW),
        .DW       (DW),
        .CLR_VAL  (CLR),
        .BELL_CYC (24'd10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_pos   (key_pos),
        .clr_req   (clr_req),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .caso      (caso)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_press(input int p);
        wr_t e;
        bank_m[p] = (bank_m[p] + 1) % (1 << DW);
        e.addr = p;
        e.data = bank_m[p];
        exp_q.push_back(e);
    endfunction

    function automatic void model_clear();
        wr_t e;
        for (int i = 0; i < DEPTH; i++) begin
            bank_m[i] = int'(CLR);
            e.addr = i;
            e.data = int'(CLR);
            exp_q.push_back(e);
        end
    endfunction

    // Write monitor: every strobe must match the next write the model predicted.
    wr_t mon_e;
    always @(negedge clk) begin
        if (wr_en !== 1'b0) begin
            chk("write_expected", exp_q.size() > 0, 1);
            chk("busy_during_wr", busy, 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", wr_addr, mon_e.addr);
                chk("wr_data", wr_data, mon_e.data);
            end
        end
`ifndef BANCO_CTRL_BELL_EN
        chk("caso_silent", caso, 0);
`endif
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < 300) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0) quiet++;
            else quiet = 0;
        end
        chk({tag, "_idle_timeout"}, quiet >= 4, 1);
        chk({tag, "_drain"}, exp_q.size(), 0);
        cyc(1);
    endtask

    task automatic press_lat(input int p, input string tag);
        model_press(p);
        chk({tag, "_busy_pre"}, busy, 0);
        key_pos = AW'(p);
        key_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_wr_en_cyc1"}, wr_en, 0);
        @(negedge clk);
        chk({tag, "_wr_en_cyc2"}, wr_en, 1);
        cyc(1);
        key_valid = 1'b0;
    endtask

    task automatic count_tone(input logic [7:0] code, input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (caso === code) n++;
        end
        chk({tag, "_cycles"}, n, 10);
        chk({tag, "_final"}, caso, 0);
        cyc(1);
    endtask

    initial begin
        int op, p, q, off, n, k;
        for (int i = 0; i < DEPTH; i++) bank_m[i] = 0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_caso", caso, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc(2);

        // Two presses on position 5
        press_lat(5, "p5a");
        wait_idle("p5a");
        press_lat(5, "p5b");
        wait_idle("p5b");

        // Eight presses on position 3: 1..7 then wrap to 0
        for (int i = 0; i < 8; i++) begin
            press_lat(3, "p3");
            wait_idle("p3");
        end

        // Bulk clear: 16 contiguous strobes, busy throughout
        model_clear();
        clr_req = 1'b1;
        n = 0;
        k = 0;
        while (busy !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("clr_start", busy, 1);
        while (busy === 1'b1 && wr_en === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("clr_len", n, 16);
        chk("clr_busy_after", busy, 0);
        clr_req = 1'b0;
        wait_idle("clr");

        // Key and clear edges together: clear first, then key 9 -> CLR+1
        model_clear();
        model_press(9);
        key_pos = AW'(9);
        key_valid = 1'b1;
        clr_req = 1'b1;
        cyc(2);
        key_valid = 1'b0;
        clr_req = 1'b0;
        wait_idle("both");

        // Reset during the 6th clear cycle
        for (int i = 0; i < 6; i++) begin
            wr_t e;
            e.addr = i;
            e.data = int'(CLR);
            exp_q.push_back(e);
        end
        clr_req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(wr_en === 1'b1 && wr_addr === AW'(5)) && k < 30);
        chk("abort_reached", wr_addr, 5);
        #2 rst = 1'b0;
        #1;
        chk("abort_wr_en", wr_en, 0);
        chk("abort_wr_addr", wr_addr, 0);
        chk("abort_wr_data", wr_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_caso", caso, 0);
        chk("abort_drain", exp_q.size(), 0);
        for (int i = 0; i < DEPTH; i++) bank_m[i] = 0;
        cyc(1);
        rst = 1'b1;
        cyc(20);
        chk("abort_no_resume", busy, 0);
        clr_req = 1'b0;
        cyc(2);
        press_lat(0, "p0");
        wait_idle("p0");

`ifdef BANCO_CTRL_BELL_EN
        cyc(20);
        model_press(7);
        key_pos = AW'(7);
        key_valid = 1'b1;
        cyc(2);
        key_valid = 1'b0;
        count_tone(8'd1, "tone_key");
        model_clear();
        clr_req = 1'b1;
        cyc(2);
        clr_req = 1'b0;
        count_tone(8'd2, "tone_clr");
        chk("tone_drain", exp_q.size(), 0);
`endif

        // Randomized operations
        for (int it = 0; it < 30; it++) begin
            op  = $urandom_range(0, 4);
            p   = $urandom_range(0, DEPTH - 1);
            q   = $urandom_range(0, DEPTH - 1);
            off = $urandom_range(1, 6);
            case (op)
                0: begin
                    model_press(p);
                    key_pos = AW'(p);
                    key_valid = 1'b1;
                    cyc(2);
                    key_valid = 1'b0;
                end
                1: begin
                    model_clear();
                    clr_req = 1'b1;
                    cyc(2);
                    clr_req = 1'b0;
                end
                2: begin
                    model_clear();
                    model_press(p);
                    key_pos = AW'(p);
                    key_valid = 1'b1;
                    clr_req = 1'b1;
                    cyc(2);
                    key_valid = 1'b0;
                    clr_req = 1'b0;
                end
                3: begin
                    // Two keys during a clear: only the later one is written
                    model_clear();
                    model_press(q);
                    clr_req = 1'b1;
                    cyc(off);
                    clr_req = 1'b0;
                    key_pos = AW'(p);
                    key_valid = 1'b1;
                    cyc(2);
                    key_valid = 1'b0;
                    cyc(2);
                    key_pos = AW'(q);
                    key_valid = 1'b1;
                    cyc(2);
                    key_valid = 1'b0;
                end
                default: begin
                    // Clear edge lands while the key write is in progress
                    model_press(p);
                    model_clear();
                    key_pos = AW'(p);
                    key_valid = 1'b1;
                    cyc(1);
                    clr_req = 1'b1;
                    cyc(1);
                    key_valid = 1'b0;
                    cyc(1);
                    clr_req = 1'b0;
                end
            endcase
            wait_idle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
